// File: rtl/mem_access_unit.sv
// mem_access_unit
//   Memory stage load/store unit. It decodes the EX/MEM access and raises a
//   misalignment exception, or issues a single request to the data cache. It
//   then waits for the response, with a bounded timeout, and returns the
//   aligned, extended load data.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   ex_valid                 EX/MEM register holds a valid instruction
//   ex_ld_type[2:0]          0 none, 1 LB, 2 LH, 3 LW, 4 LBU, 5 LHU, 6 LD, 7 LWU
//   ex_st_type[2:0]          0 none, 1 SB, 2 SH, 3 SW, 4 SD, 5-7 illegal
//   ex_addr, ex_wdata        effective address, right-aligned store data
//   csr_flush                pipeline flush from the CSR unit
//   dc_req/we/addr/be/wdata  data cache request bus
//   dc_gnt/rvalid/err/rdata  data cache grant and response
//   mem_ld_en                load present in MEM (forwarding / hazards)
//   mem_stall                pipeline stall request
//   mem_wb_valid/data        completed access and extended load data
//   mem_exc_misalign/bus     one-cycle exception pulses
module mem_access_unit #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 32,
   parameter int TIMEOUT    = 255
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    ex_valid,
   input  logic [2:0]              ex_ld_type,
   input  logic [2:0]              ex_st_type,
   input  logic [ADDR_WIDTH-1:0]   ex_addr,
   input  logic [DATA_WIDTH-1:0]   ex_wdata,
   input  logic                    csr_flush,
   output logic                    dc_req,
   output logic                    dc_we,
   output logic [ADDR_WIDTH-1:0]   dc_addr,
   output logic [DATA_WIDTH/8-1:0] dc_be,
   output logic [DATA_WIDTH-1:0]   dc_wdata,
   input  logic                    dc_gnt,
   input  logic                    dc_rvalid,
   input  logic                    dc_err,
   input  logic [DATA_WIDTH-1:0]   dc_rdata,
   output logic                    mem_ld_en,
   output logic                    mem_stall,
   output logic                    mem_wb_valid,
   output logic [DATA_WIDTH-1:0]   mem_wb_data,
   output logic                    mem_exc_misalign,
   output logic                    mem_exc_bus
);

   localparam int BW = DATA_WIDTH / 8;
   localparam int OW = $clog2(BW);

   typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;
   state_t state, state_n;

   logic                  is_load, active, illegal, misaligned, accept;
   logic [1:0]            lg_size;
   logic [OW-1:0]         off, low_mask;
   logic [BW-1:0]         be_base, be_n;
   logic [DATA_WIDTH-1:0] wdata_n;
   logic [15:0]           cnt;
   logic                  timeout_hit, rsp_done;
   logic                  retire_q, flush_q;
   logic [2:0]            ld_q;
   logic [OW-1:0]         off_q;
   logic [DATA_WIDTH-1:0] shifted, ext;

   assign off       = ex_addr[OW-1:0];
   assign is_load   = (ex_ld_type != 3'd0);
   assign active    = ex_valid && (is_load || (ex_st_type != 3'd0));
   assign mem_ld_en = ex_valid && is_load;

   // Access size as log2(bytes); the load type wins when both are set.
   always_comb begin
      lg_size = 2'd0;
      illegal = 1'b0;
      if (is_load) begin
         case (ex_ld_type)
            3'd1, 3'd4: lg_size = 2'd0;
            3'd2, 3'd5: lg_size = 2'd1;
            3'd3, 3'd7: lg_size = 2'd2;
            default:    lg_size = 2'd3;
         endcase
         if ((DATA_WIDTH == 32) && ((ex_ld_type == 3'd6) || (ex_ld_type == 3'd7)))
            illegal = 1'b1;
      end else begin
         case (ex_st_type)
            3'd1:    lg_size = 2'd0;
            3'd2:    lg_size = 2'd1;
            3'd3:    lg_size = 2'd2;
            3'd4:    lg_size = 2'd3;
            default: illegal = 1'b1;
         endcase
         if ((DATA_WIDTH == 32) && (ex_st_type == 3'd4))
            illegal = 1'b1;
      end
   end

   always_comb begin
      case (lg_size)
         2'd0:    begin low_mask = '0;        be_base = BW'(1);     end
         2'd1:    begin low_mask = OW'(1);    be_base = BW'(3);     end
         2'd2:    begin low_mask = OW'(3);    be_base = BW'(8'h0F); end
         default: begin low_mask = '1;        be_base = '1;         end
      endcase
   end

   assign misaligned = illegal || ((off & low_mask) != '0);
   assign be_n       = be_base << off;

   // Replicate the store element across the bus so every lane holds the
   // byte that belongs at that offset.
   always_comb begin
      int unsigned sz;
      wdata_n = '0;
      sz      = 32'd1 << lg_size;
      for (int unsigned i = 0; i < BW; i++)
         wdata_n[i*8 +: 8] = ex_wdata[(i % sz)*8 +: 8];
   end

   // retire_q blocks re-acceptance in the cycle after completion: the
   // pipeline is released then, so EX still shows the finished instruction.
   assign accept = (state == IDLE) && !rst && !retire_q && active && !misaligned &&
                   (is_load || !csr_flush);

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_n;
   end

   always_comb begin
      state_n     = state;
      dc_req      = 1'b0;
      timeout_hit = 1'b0;
      rsp_done    = 1'b0;
      case (state)
         IDLE: if (accept) state_n = REQ;
         REQ: begin
            dc_req = 1'b1;
            if (dc_gnt) state_n = WAIT;
         end
         WAIT: begin
            if (dc_rvalid) begin
               rsp_done = 1'b1;
               state_n  = IDLE;
            end else if (cnt == 16'(TIMEOUT - 1)) begin
               timeout_hit = 1'b1;
               state_n     = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   assign mem_stall = (state != IDLE) || accept;

   always_comb begin
      shifted = dc_rdata >> {off_q, 3'b000};
      case (ld_q)
         3'd1:    ext = DATA_WIDTH'($signed(shifted[7:0]));
         3'd2:    ext = DATA_WIDTH'($signed(shifted[15:0]));
         3'd3:    ext = DATA_WIDTH'($signed(shifted[31:0]));
         3'd4:    ext = DATA_WIDTH'(shifted[7:0]);
         3'd5:    ext = DATA_WIDTH'(shifted[15:0]);
         3'd6:    ext = shifted;
         3'd7:    ext = DATA_WIDTH'(shifted[31:0]);
         default: ext = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         dc_we            <= 1'b0;
         dc_addr          <= '0;
         dc_be            <= '0;
         dc_wdata         <= '0;
         mem_wb_valid     <= 1'b0;
         mem_wb_data      <= '0;
         mem_exc_misalign <= 1'b0;
         mem_exc_bus      <= 1'b0;
         cnt              <= '0;
         retire_q         <= 1'b0;
         flush_q          <= 1'b0;
         ld_q             <= '0;
         off_q            <= '0;
      end else begin
         mem_wb_valid     <= 1'b0;
         mem_exc_bus      <= 1'b0;
         mem_exc_misalign <= (state == IDLE) && active && misaligned;
         retire_q         <= rsp_done || timeout_hit;
         if (accept) begin
            dc_addr  <= ex_addr & ~ADDR_WIDTH'(BW - 1);
            dc_be    <= be_n;
            dc_wdata <= wdata_n;
            dc_we    <= !is_load;
            ld_q     <= is_load ? ex_ld_type : 3'd0;
            off_q    <= off;
            flush_q  <= 1'b0;
         end
         // A flush after issue lets the access finish but hides its result.
         if ((state != IDLE) && csr_flush)
            flush_q <= 1'b1;
         if (state == REQ)
            cnt <= '0;
         else if (state == WAIT)
            cnt <= cnt + 16'd1;
         if (rsp_done) begin
            mem_wb_valid <= !dc_err && !flush_q && !csr_flush;
            mem_exc_bus  <= dc_err;
            mem_wb_data  <= ext;
         end
         if (timeout_hit)
            mem_exc_bus <= 1'b1;
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit
//   Bench for mem_access_unit: a 32-bit instance with a short timeout carries
//   a scoreboard of expected completions/exceptions, and a 64-bit instance
//   covers the wide-bus lane placement.
module tb_mem_access_unit;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst;

   // 32-bit instance
   logic        ex_valid, csr_flush;
   logic [2:0]  ex_ld_type, ex_st_type;
   logic [31:0] ex_addr, ex_wdata;
   logic        dc_req, dc_we;
   logic [31:0] dc_addr, dc_wdata;
   logic [3:0]  dc_be;
   logic        dc_gnt, dc_rvalid, dc_err;
   logic [31:0] dc_rdata;
   logic        mem_ld_en, mem_stall, mem_wb_valid, mem_exc_misalign, mem_exc_bus;
   logic [31:0] mem_wb_data;

   // 64-bit instance
   logic        w_ex_valid, w_csr_flush;
   logic [2:0]  w_ex_ld_type, w_ex_st_type;
   logic [31:0] w_ex_addr;
   logic [63:0] w_ex_wdata;
   logic        w_dc_req, w_dc_we;
   logic [31:0] w_dc_addr;
   logic [63:0] w_dc_wdata;
   logic [7:0]  w_dc_be;
   logic        w_dc_gnt, w_dc_rvalid, w_dc_err;
   logic [63:0] w_dc_rdata;
   logic        w_mem_ld_en, w_mem_stall, w_mem_wb_valid, w_mem_exc_misalign, w_mem_exc_bus;
   logic [63:0] w_mem_wb_data;

   mem_access_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .TIMEOUT(4)) dut (
      .clk(clk), .rst(rst), .ex_valid(ex_valid), .ex_ld_type(ex_ld_type),
      .ex_st_type(ex_st_type), .ex_addr(ex_addr), .ex_wdata(ex_wdata),
      .csr_flush(csr_flush), .dc_req(dc_req), .dc_we(dc_we), .dc_addr(dc_addr),
      .dc_be(dc_be), .dc_wdata(dc_wdata), .dc_gnt(dc_gnt), .dc_rvalid(dc_rvalid),
      .dc_err(dc_err), .dc_rdata(dc_rdata), .mem_ld_en(mem_ld_en),
      .mem_stall(mem_stall), .mem_wb_valid(mem_wb_valid), .mem_wb_data(mem_wb_data),
      .mem_exc_misalign(mem_exc_misalign), .mem_exc_bus(mem_exc_bus)
   );

   mem_access_unit #(.DATA_WIDTH(64), .ADDR_WIDTH(32), .TIMEOUT(255)) dut64 (
      .clk(clk), .rst(rst), .ex_valid(w_ex_valid), .ex_ld_type(w_ex_ld_type),
      .ex_st_type(w_ex_st_type), .ex_addr(w_ex_addr), .ex_wdata(w_ex_wdata),
      .csr_flush(w_csr_flush), .dc_req(w_dc_req), .dc_we(w_dc_we), .dc_addr(w_dc_addr),
      .dc_be(w_dc_be), .dc_wdata(w_dc_wdata), .dc_gnt(w_dc_gnt), .dc_rvalid(w_dc_rvalid),
      .dc_err(w_dc_err), .dc_rdata(w_dc_rdata), .mem_ld_en(w_mem_ld_en),
      .mem_stall(w_mem_stall), .mem_wb_valid(w_mem_wb_valid), .mem_wb_data(w_mem_wb_data),
      .mem_exc_misalign(w_mem_exc_misalign), .mem_exc_bus(w_mem_exc_bus)
   );

   int unsigned n_checks = 0;
   int unsigned n_errors = 0;

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Scoreboard of result events for the 32-bit instance.
   localparam int EV_WB  = 0;
   localparam int EV_BUS = 1;
   localparam int EV_MIS = 2;
   typedef struct {
      int          kind;
      logic [31:0] data;
   } ev_t;
   ev_t sb[$];
   ev_t mon_e;
   int  mon_kind;

   always @(negedge clk) begin
      if (!rst && (mem_wb_valid || mem_exc_bus || mem_exc_misalign)) begin
         mon_kind = mem_wb_valid ? EV_WB : (mem_exc_bus ? EV_BUS : EV_MIS);
         if (sb.size() == 0) begin
            check("sb_unexpected", 128'({mem_wb_valid, mem_exc_bus, mem_exc_misalign}), 128'(0));
         end else begin
            mon_e = sb.pop_front();
            check("sb_kind", 128'(mon_kind), 128'(mon_e.kind));
            if (mon_e.kind == EV_WB)
               check("sb_data", 128'(mem_wb_data), 128'(mon_e.data));
         end
      end
   end

   // One access on the 32-bit instance, grant after gnt_wait extra REQ
   // cycles, response one cycle after grant. Returns at the negedge where the
   // registered result is visible (or one cycle after acceptance if no
   // request was issued).
   task automatic run_access(input logic [2:0] ld, input logic [2:0] st,
                             input logic [31:0] addr, input logic [31:0] wdata,
                             input logic [31:0] rdata, input logic flush_idle,
                             input int unsigned gnt_wait, input logic flush_wait,
                             input logic err, input logic [31:0] exp_addr,
                             input logic [3:0] exp_be, input logic [31:0] exp_wdata,
                             output logic acc_stall, output logic saw_req);
      logic exp_we;
      exp_we = (ld == 3'd0);
      @(negedge clk);
      ex_valid = 1'b1; ex_ld_type = ld; ex_st_type = st;
      ex_addr = addr; ex_wdata = wdata; csr_flush = flush_idle;
      #1;
      acc_stall = mem_stall;
      check("ld_en", 128'(mem_ld_en), 128'(ld != 3'd0));
      @(negedge clk);
      ex_valid = 1'b0; ex_ld_type = '0; ex_st_type = '0; csr_flush = 1'b0;
      saw_req = dc_req;
      if (saw_req) begin
         for (int unsigned i = 0; i <= gnt_wait; i++) begin
            if (i != 0) @(negedge clk);
            check("req_fields", 128'({dc_req, dc_addr, dc_be, dc_we}),
                  128'({1'b1, exp_addr, exp_be, exp_we}));
            if (exp_we) check("req_wdata", 128'(dc_wdata), 128'(exp_wdata));
         end
         dc_gnt = 1'b1;
         @(negedge clk);
         dc_gnt = 1'b0; csr_flush = flush_wait;
         check("wait_stall", 128'(mem_stall), 128'(1));
         dc_rvalid = 1'b1; dc_err = err; dc_rdata = rdata;
         @(negedge clk);
         dc_rvalid = 1'b0; dc_err = 1'b0; csr_flush = 1'b0;
      end
   endtask

   task automatic run64(input logic [2:0] ld, input logic [2:0] st, input logic [31:0] addr,
                        input logic [63:0] wdata, input logic [63:0] rdata,
                        input logic [31:0] exp_addr, input logic [7:0] exp_be,
                        input logic [63:0] exp_wdata, input logic [63:0] exp_data);
      @(negedge clk);
      w_ex_valid = 1'b1; w_ex_ld_type = ld; w_ex_st_type = st;
      w_ex_addr = addr; w_ex_wdata = wdata;
      #1;
      check("w_accept", 128'({w_mem_stall, w_mem_ld_en}), 128'({1'b1, ld != 3'd0}));
      @(negedge clk);
      w_ex_valid = 1'b0; w_ex_ld_type = '0; w_ex_st_type = '0;
      check("w_req", 128'({w_dc_req, w_dc_addr, w_dc_be, w_dc_we}),
            128'({1'b1, exp_addr, exp_be, ld == 3'd0}));
      if (ld == 3'd0) check("w_wdata", 128'(w_dc_wdata), 128'(exp_wdata));
      w_dc_gnt = 1'b1;
      @(negedge clk);
      w_dc_gnt = 1'b0; w_dc_rvalid = 1'b1; w_dc_rdata = rdata;
      @(negedge clk);
      w_dc_rvalid = 1'b0;
      check("w_wb", 128'({w_mem_wb_valid, w_mem_exc_bus, w_mem_wb_data}),
            128'({1'b1, 1'b0, exp_data}));
   endtask

   initial begin
      #50000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic acc_stall, saw_req;
      int unsigned wait_n;

      ex_valid = 1'b0; ex_ld_type = '0; ex_st_type = '0; ex_addr = '0; ex_wdata = '0;
      csr_flush = 1'b0; dc_gnt = 1'b0; dc_rvalid = 1'b0; dc_err = 1'b0; dc_rdata = '0;
      w_ex_valid = 1'b0; w_ex_ld_type = '0; w_ex_st_type = '0; w_ex_addr = '0;
      w_ex_wdata = '0; w_csr_flush = 1'b0; w_dc_gnt = 1'b0; w_dc_rvalid = 1'b0;
      w_dc_err = 1'b0; w_dc_rdata = '0;

      // Reset with an aligned load pending in EX: nothing may start.
      rst = 1'b1;
      ex_valid = 1'b1; ex_ld_type = 3'd3; ex_addr = 32'h100;
      repeat (3) @(negedge clk);
      check("rst_bus", 128'({dc_req, dc_we, dc_be, dc_addr, dc_wdata}), 128'(0));
      check("rst_out", 128'({mem_wb_valid, mem_wb_data, mem_exc_misalign, mem_exc_bus, mem_stall}),
            128'(0));
      ex_valid = 1'b0; ex_ld_type = '0; ex_addr = '0;
      rst = 1'b0;

      // LB, same-cycle grant, next-cycle response: 3-cycle latency.
      sb.push_back('{EV_WB, 32'hFFFF_FF80});
      run_access(3'd1, 3'd0, 32'h1003, 32'h0, 32'h8000_0000, 1'b0, 0, 1'b0, 1'b0,
                 32'h1000, 4'b1000, 32'h0, acc_stall, saw_req);
      check("lb_acc_stall", 128'(acc_stall), 128'(1));
      check("lb_latency", 128'(mem_wb_valid), 128'(1));
      check("lb_wb_stall", 128'(mem_stall), 128'(0));

      // SH: half-word replicated, upper lanes enabled.
      sb.push_back('{EV_WB, 32'h0});
      run_access(3'd0, 3'd2, 32'h2002, 32'h0000_BEEF, 32'h1234_5678, 1'b0, 0, 1'b0, 1'b0,
                 32'h2000, 4'b1100, 32'hBEEF_BEEF, acc_stall, saw_req);
      check("sh_req", 128'(saw_req), 128'(1));

      // Misaligned LW: pulse only, no request, no stall.
      sb.push_back('{EV_MIS, 32'h0});
      run_access(3'd3, 3'd0, 32'h1001, 32'h0, 32'h0, 1'b0, 0, 1'b0, 1'b0,
                 32'h0, 4'b0, 32'h0, acc_stall, saw_req);
      check("mis_noreq", 128'({saw_req, acc_stall, mem_exc_misalign}), 128'(3'b001));

      // Extension and lane selection patterns.
      sb.push_back('{EV_WB, 32'h0000_8001});
      run_access(3'd5, 3'd0, 32'h3002, 32'h0, 32'h8001_1234, 1'b0, 0, 1'b0, 1'b0,
                 32'h3000, 4'b1100, 32'h0, acc_stall, saw_req);
      sb.push_back('{EV_WB, 32'hFFFF_F00D});
      run_access(3'd2, 3'd0, 32'h3000, 32'h0, 32'h1234_F00D, 1'b0, 0, 1'b0, 1'b0,
                 32'h3000, 4'b0011, 32'h0, acc_stall, saw_req);
      sb.push_back('{EV_WB, 32'hDEAD_BEEF});
      run_access(3'd3, 3'd0, 32'h3004, 32'h0, 32'hDEAD_BEEF, 1'b0, 2, 1'b0, 1'b0,
                 32'h3004, 4'b1111, 32'h0, acc_stall, saw_req);
      sb.push_back('{EV_WB, 32'h0});
      run_access(3'd0, 3'd1, 32'h4001, 32'h1234_56A5, 32'h0, 1'b0, 0, 1'b0, 1'b0,
                 32'h4000, 4'b0010, 32'hA5A5_A5A5, acc_stall, saw_req);
      sb.push_back('{EV_WB, 32'h0000_00AB});
      run_access(3'd4, 3'd0, 32'h4002, 32'h0, 32'h00AB_0000, 1'b0, 0, 1'b0, 1'b0,
                 32'h4000, 4'b0100, 32'h0, acc_stall, saw_req);

      // Store under flush in IDLE never issues.
      run_access(3'd0, 3'd3, 32'h7000, 32'h1111_2222, 32'h0, 1'b1, 0, 1'b0, 1'b0,
                 32'h7000, 4'b1111, 32'h1111_2222, acc_stall, saw_req);
      check("flush_st", 128'({saw_req, acc_stall}), 128'(2'b00));

      // Flush during WAIT: response consumed, result hidden.
      run_access(3'd3, 3'd0, 32'h3008, 32'h0, 32'h5555_AAAA, 1'b0, 0, 1'b1, 1'b0,
                 32'h3008, 4'b1111, 32'h0, acc_stall, saw_req);
      check("flush_wait", 128'({saw_req, mem_wb_valid, mem_stall}), 128'(3'b100));

      // Response error.
      sb.push_back('{EV_BUS, 32'h0});
      run_access(3'd3, 3'd0, 32'h300C, 32'h0, 32'h0, 1'b0, 0, 1'b0, 1'b1,
                 32'h300C, 4'b1111, 32'h0, acc_stall, saw_req);
      check("err_bus", 128'({mem_exc_bus, mem_wb_valid}), 128'(2'b10));

      // LD on a 32-bit bus and illegal store type 5 are misaligned.
      sb.push_back('{EV_MIS, 32'h0});
      run_access(3'd6, 3'd0, 32'h5000, 32'h0, 32'h0, 1'b0, 0, 1'b0, 1'b0,
                 32'h0, 4'b0, 32'h0, acc_stall, saw_req);
      check("ld32_noreq", 128'(saw_req), 128'(0));
      sb.push_back('{EV_MIS, 32'h0});
      run_access(3'd0, 3'd5, 32'h5000, 32'h0, 32'h0, 1'b0, 0, 1'b0, 1'b0,
                 32'h0, 4'b0, 32'h0, acc_stall, saw_req);
      check("st5_noreq", 128'(saw_req), 128'(0));

      // Load and store both set: load wins.
      sb.push_back('{EV_WB, 32'h1122_3344});
      run_access(3'd3, 3'd3, 32'h5000, 32'hFFFF_FFFF, 32'h1122_3344, 1'b0, 0, 1'b0, 1'b0,
                 32'h5000, 4'b1111, 32'h0, acc_stall, saw_req);

      // Timeout after 4 WAIT cycles; a late response is dropped.
      sb.push_back('{EV_BUS, 32'h0});
      @(negedge clk);
      ex_valid = 1'b1; ex_ld_type = 3'd3; ex_addr = 32'h6000;
      @(negedge clk);
      ex_valid = 1'b0; ex_ld_type = '0;
      check("to_req", 128'(dc_req), 128'(1));
      dc_gnt = 1'b1;
      @(negedge clk);
      dc_gnt = 1'b0;
      wait_n = 0;
      while (!mem_exc_bus && wait_n < 10) begin
         @(negedge clk);
         wait_n++;
      end
      check("to_cycles", 128'(wait_n), 128'(4));
      dc_rvalid = 1'b1; dc_rdata = 32'hCAFE_0000;
      @(negedge clk);
      dc_rvalid = 1'b0;
      check("to_late_rv", 128'({mem_wb_valid, dc_req, mem_stall}), 128'(0));

      // Reset during WAIT abandons the access.
      @(negedge clk);
      ex_valid = 1'b1; ex_ld_type = 3'd3; ex_addr = 32'h6100;
      @(negedge clk);
      ex_valid = 1'b0; ex_ld_type = '0;
      dc_gnt = 1'b1;
      @(negedge clk);
      dc_gnt = 1'b0; rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("rst_wait", 128'({dc_req, mem_stall}), 128'(0));
      dc_rvalid = 1'b1; dc_rdata = 32'h1234_0000;
      @(negedge clk);
      dc_rvalid = 1'b0;
      check("rst_late_rv", 128'({mem_wb_valid, mem_exc_bus}), 128'(0));
      @(negedge clk);
      check("sb_drained", 128'(sb.size()), 128'(0));

      // 64-bit bus.
      run64(3'd7, 3'd0, 32'h1004, 64'h0, 64'h9000_0001_1234_5678,
            32'h1000, 8'hF0, 64'h0, 64'h0000_0000_9000_0001);
      run64(3'd0, 3'd3, 32'h100C, 64'h0000_0000_CAFE_F00D, 64'h0,
            32'h1008, 8'hF0, 64'hCAFE_F00D_CAFE_F00D, 64'h0);
      run64(3'd1, 3'd0, 32'h2007, 64'h0, 64'h8877_6655_4433_2211,
            32'h2000, 8'h80, 64'h0, 64'hFFFF_FFFF_FFFF_FF88);
      run64(3'd6, 3'd0, 32'h2008, 64'h0, 64'h8877_6655_4433_2211,
            32'h2008, 8'hFF, 64'h0, 64'h8877_6655_4433_2211);
      @(negedge clk);
      w_ex_valid = 1'b1; w_ex_st_type = 3'd4; w_ex_addr = 32'h2004;
      @(negedge clk);
      w_ex_valid = 1'b0; w_ex_st_type = '0;
      check("w_sd_misalign", 128'({w_dc_req, w_mem_exc_misalign}), 128'(2'b01));

      repeat (2) @(negedge clk);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
